bcd_to_bin: RTL and testbench

- Sequential BCD-to-binary converter (reverse double-dabble, shift-right and subtract-3). Inverse of the existing binary-to-BCD digit path.
- Takes a packed DIGITS-digit BCD word and produces its binary value after a fixed multi-cycle conversion.
- Sits between BCD entry/readback logic (units/tens/hundreds digits) and binary datapaths such as counters and compare thresholds.
- Start/busy/done handshake. Invalid digits are flagged, not converted.

---
 rtl/bcd_to_bin.sv | 104 ++++++++++
 tb/tb_bcd_to_bin.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential BCD-to-binary converter (reverse double-dabble)
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CAT_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    logic [BCD_W-1:0]   bcd_sr;
    logic [BIN_W-1:0]   bin_sr;
    logic [CNT_W-1:0]   cnt;

    logic               bad_digit;
    logic [CAT_W-1:0]   shifted;
    logic [BCD_W-1:0]   bcd_nxt;
    logic [BIN_W-1:0]   bin_nxt;

    // Flag an operand carrying any nibble outside 0..9
    always_comb begin
        bad_digit = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // One conversion step: shift the pair right, then pull each digit >= 8 back by 3
    always_comb begin
        shifted = {bcd_sr, bin_sr} >> 1;
        bcd_nxt = shifted[CAT_W-1:BIN_W];
        bin_nxt = shifted[BIN_W-1:0];
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_nxt[4*d +: 4] >= 4'd8) begin
                bcd_nxt[4*d +: 4] = bcd_nxt[4*d +: 4] - 4'd3;
            end
        end
    end

    // Control FSM with registered busy/done/bin/err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            bin    <= '0;
            bcd_sr <= '0;
            bin_sr <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad_digit) begin
                            // Rejected operands complete immediately with a zero result
                            err  <= 1'b1;
                            bin  <= '0;
                            done <= 1'b1;
                        end else begin
                            err    <= 1'b0;
                            bcd_sr <= bcd;
                            bin_sr <= '0;
                            cnt    <= CNT_W'(BIN_W);
                            busy   <= 1'b1;
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    bcd_sr <= bcd_nxt;
                    bin_sr <= bin_nxt;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        bin   <= bin_nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - self-checking bench for bcd_to_bin
module tb_bcd_to_bin;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bcd;
    logic        busy;
    logic        done;
    logic [9:0]  bin;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];

    bcd_to_bin #(.DIGITS(3), .BIN_W(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] ref_model(input logic [11:0] b);
        int v;
        if (b[3:0] > 4'd9 || b[7:4] > 4'd9 || b[11:8] > 4'd9) return {1'b1, 10'd0};
        v = int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
        return {1'b0, 10'(v)};
    endfunction

    // Scoreboard: every done pulse pops the oldest expected result
    always @(negedge clk) begin
        if (!rst && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done bin=%0d err=%0b with empty scoreboard", bin, err);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                checks++;
                if (bin !== e[9:0]) begin
                    errors++;
                    $display("FAIL result_bin got=%0d expected=%0d", bin, e[9:0]);
                end
                if (err !== e[10]) begin
                    errors++;
                    $display("FAIL result_err got=%0b expected=%0b", err, e[10]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse; returns just after the accept edge
    task automatic kick(input logic [11:0] v, input bit push);
        bcd   = v;
        start = 1'b1;
        if (push) exp_q.push_back(ref_model(v));
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for done; reports edges waited and cycles busy was seen high
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bcd = 12'h000;
        repeat (2) tick();
        checks++;
        if ({busy, done, err, bin} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state busy=%0b done=%0b err=%0b bin=%0d expected all 0", busy, done, err, bin);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [11:0] vals[4] = '{12'h255, 12'h999, 12'h000, 12'h100};
        int lat, bc;
        foreach (vals[i]) begin
            kick(vals[i], 1'b1);
            wait_done(lat, bc);
            checks++;
            if (lat != 10 || bc != 10) begin
                errors++;
                $display("FAIL basic_latency bcd=%h lat=%0d busy_cycles=%0d expected 10/10", vals[i], lat, bc);
            end
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL basic_done_pulse done=%0b busy=%0b expected 0/0", done, busy);
            end
        end
    endtask

    task automatic test_invalid();
        int lat, bc;
        kick(12'h1A5, 1'b1);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL invalid_immediate done=%0b busy=%0b err=%0b expected 1/0/1", done, busy, err);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL invalid_hold done=%0b busy=%0b err=%0b expected 0/0/1", done, busy, err);
        end
        kick(12'h042, 1'b1);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL invalid_clear err=%0b busy=%0b expected 0/1", err, busy);
        end
        wait_done(lat, bc);
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL invalid_next_latency lat=%0d expected 10", lat);
        end
        tick();
    endtask

    task automatic test_ignore_busy();
        int lat, bc;
        kick(12'h123, 1'b1);
        repeat (3) tick();
        bcd = 12'h456;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, bc);
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL ignore_latency lat=%0d expected 6", lat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        kick(12'h123, 1'b1);
        repeat (9) tick();
        bcd = 12'h456;
        start = 1'b1;
        exp_q.push_back(ref_model(12'h456));
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done done=%0b expected 1", done);
        end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_gap busy=%0b expected 1", busy);
        end
        wait_done(lat, bc);
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL b2b_latency lat=%0d expected 10", lat);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int lat, bc, seen;
        kick(12'h789, 1'b0);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, bin} !== 13'd0) begin
            errors++;
            $display("FAIL abort_async busy=%0b done=%0b err=%0b bin=%0d expected all 0", busy, done, err, bin);
        end
        tick();
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done activity_cycles=%0d expected 0", seen);
        end
        kick(12'h789, 1'b1);
        wait_done(lat, bc);
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL abort_restart_latency lat=%0d expected 10", lat);
        end
        tick();
    endtask

    task automatic test_sweep();
        int lat, bc, bad;
        bad = 0;
        for (int h = 0; h < 10; h++) begin
            for (int t = 0; t < 10; t++) begin
                for (int u = 0; u < 10; u++) begin
                    kick({4'(h), 4'(t), 4'(u)}, 1'b1);
                    wait_done(lat, bc);
                    if (lat != 10) bad++;
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sweep_latency bad_count=%0d expected 0", bad);
        end
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
